debounce_array: RTL and testbench



---
 rtl/debounce_array.sv | 183 ++++++++++++++++++
 tb/tb_debounce_array.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_array.sv
// rtl/debounce_array.sv - multi-channel button conditioner: sync, debounce, edges, long press, repeat
module debounce_array #(
    parameter int NUM_CH       = 5,
    parameter int SYNC_STAGES  = 2,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 70,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200,
    parameter int REPEAT_EN    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] buttons,
    output logic [NUM_CH-1:0] results,
    output logic [NUM_CH-1:0] press,
    output logic [NUM_CH-1:0] rel,
    output logic [NUM_CH-1:0] long_press,
    output logic [NUM_CH-1:0] rpt
);

    localparam int PW   = $clog2(TICK_DIV);
    localparam int DW   = $clog2(STABLE_TICKS);
    localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] D_LAST = DW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] L_LAST = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] R_LAST = HW'(REPEAT_TICKS - 1);

    if (NUM_CH < 1 || SYNC_STAGES < 2 || TICK_DIV < 2 || STABLE_TICKS < 2 ||
        LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_err
        $error("debounce_array: parameter below its minimum");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT,
        ST_DONE
    } hold_state_e;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] s;
    logic [PW-1:0]     pcnt;
    logic              tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= buttons;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign tick = (pcnt == P_LAST);

    // One prescaler for all channels keeps the per-channel counters in tick units
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DW-1:0] dcnt;
        logic          res_q;
        logic          res_d;
        logic          press_q;
        logic          rel_q;
        logic          long_q;
        logic          rpt_q;
        logic          long_d;
        logic          rpt_d;
        logic          rise;
        logic          fall;
        logic [HW-1:0] hcnt_q;
        logic [HW-1:0] hcnt_d;
        hold_state_e   st_q;
        hold_state_e   st_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dcnt  <= '0;
                res_q <= 1'b0;
            end else if (s[i] == res_q) begin
                dcnt <= '0;
            end else if (tick) begin
                if (dcnt == D_LAST) begin
                    res_q <= s[i];
                    dcnt  <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end

        assign rise = res_q & ~res_d;
        assign fall = ~res_q & res_d;

        // A debounced fall pre-empts any hold pulse due on the same cycle
        always_comb begin
            st_d   = st_q;
            hcnt_d = hcnt_q;
            long_d = 1'b0;
            rpt_d  = 1'b0;
            if (fall) begin
                st_d   = ST_IDLE;
                hcnt_d = '0;
            end else begin
                case (st_q)
                    ST_IDLE: begin
                        hcnt_d = '0;
                        if (rise) begin
                            st_d = ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (tick) begin
                            if (hcnt_q == L_LAST) begin
                                long_d = 1'b1;
                                hcnt_d = '0;
                                st_d   = (REPEAT_EN != 0) ? ST_REPEAT : ST_DONE;
                            end else begin
                                hcnt_d = hcnt_q + 1'b1;
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (tick) begin
                            if (hcnt_q == R_LAST) begin
                                rpt_d  = 1'b1;
                                hcnt_d = '0;
                            end else begin
                                hcnt_d = hcnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        hcnt_d = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_d   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                rpt_q   <= 1'b0;
                hcnt_q  <= '0;
                st_q    <= ST_IDLE;
            end else begin
                res_d   <= res_q;
                press_q <= rise;
                rel_q   <= fall;
                long_q  <= long_d;
                rpt_q   <= rpt_d;
                hcnt_q  <= hcnt_d;
                st_q    <= st_d;
            end
        end

        assign results[i]    = res_q;
        assign press[i]      = press_q;
        assign rel[i]        = rel_q;
        assign long_press[i] = long_q;
        assign rpt[i]        = rpt_q;
    end

endmodule

// File: tb/tb_debounce_array.sv
// tb/tb_debounce_array.sv - bench for debounce_array: cycle model, directed timing checks, random stimulus
module tb_debounce_array;

    localparam int NC = 5;
    localparam int SS = 2;
    localparam int TD = 4;
    localparam int ST = 8;
    localparam int LT = 20;
    localparam int RT = 5;
    localparam int RE = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NC-1:0] buttons = '0;
    logic [NC-1:0] results;
    logic [NC-1:0] press;
    logic [NC-1:0] rel;
    logic [NC-1:0] long_press;
    logic [NC-1:0] rpt;

    int n_checks = 0;
    int n_fail   = 0;

    debounce_array #(
        .NUM_CH(NC), .SYNC_STAGES(SS), .TICK_DIV(TD), .STABLE_TICKS(ST),
        .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(RE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .buttons(buttons), .results(results),
        .press(press), .rel(rel), .long_press(long_press), .rpt(rpt)
    );

    always #5 clk = ~clk;

    // Model: edge e (counted from reset release) carries a tick when e%TD==0; the
    // synchronised input seen at edge e is the button value sampled SS edges earlier.
    logic [NC-1:0] m_res = '0, m_res_p = '0, m_press = '0, m_rel = '0, m_long = '0, m_rpt = '0;
    logic [NC-1:0] m_s, m_prev1, m_prev2;
    logic [NC-1:0] m_q[$];
    bit            m_tick;
    int            m_e = 0;
    int            m_agree_miss[NC];
    int            m_held_ticks[NC];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_e = 0;
            {m_res, m_res_p, m_press, m_rel, m_long, m_rpt} = '0;
            m_q.delete();
            for (int k = 0; k < SS; k++) m_q.push_back('0);
            for (int c = 0; c < NC; c++) begin
                m_agree_miss[c] = 0;
                m_held_ticks[c] = 0;
            end
        end else begin
            m_e++;
            m_tick = (m_e % TD == 0);
            m_s = m_q.pop_front();
            m_q.push_back(buttons);
            m_prev1 = m_res;
            m_prev2 = m_res_p;
            for (int c = 0; c < NC; c++) begin
                if (m_s[c] == m_prev1[c]) begin
                    m_agree_miss[c] = 0;
                end else if (m_tick) begin
                    m_agree_miss[c]++;
                    if (m_agree_miss[c] == ST) begin
                        m_res[c] = m_s[c];
                        m_agree_miss[c] = 0;
                    end
                end
                m_press[c] = m_prev1[c] & ~m_prev2[c];
                m_rel[c]   = ~m_prev1[c] & m_prev2[c];
                m_long[c]  = 1'b0;
                m_rpt[c]   = 1'b0;
                if (m_prev1[c] && m_prev2[c]) begin
                    if (m_tick) begin
                        m_held_ticks[c]++;
                        if (m_held_ticks[c] == LT)
                            m_long[c] = 1'b1;
                        else if (RE != 0 && m_held_ticks[c] > LT && (m_held_ticks[c] - LT) % RT == 0)
                            m_rpt[c] = 1'b1;
                    end
                end else begin
                    m_held_ticks[c] = 0;
                end
            end
            m_res_p = m_prev1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    always @(negedge clk) begin
        chk("model_results", results, m_res);
        chk("model_press", press, m_press);
        chk("model_release", rel, m_rel);
        chk("model_long_press", long_press, m_long);
        chk("model_rpt", rpt, m_rpt);
    end

    function automatic logic [NC-1:0] get_sig(input int which);
        case (which)
            0:       return results;
            1:       return press;
            2:       return rel;
            3:       return long_press;
            default: return rpt;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bit(input string name, input int ch, input int which, input int limit,
                            output int waited);
        logic [NC-1:0] v;
        waited = 0;
        v = '0;
        while (!v[ch] && waited < limit) begin
            step();
            waited++;
            v = get_sig(which);
        end
        if (!v[ch]) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no pulse within %0d cycles", name, limit);
            waited = -1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int rise_n, press_n, cnt_a, cnt_b, cnt_c, bad, w, ch, dur;

    initial begin
        buttons = 5'h1F;
        #50;
        chk("reset_outputs", {results, press, rel, long_press, rpt}, '0);
        #52;
        rst_n = 1'b1;
        rise_n = 0; press_n = 0; cnt_a = 0;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (rise_n == 0 && results == 5'h1F) rise_n = n;
            if (press == 5'h1F) begin
                cnt_a++;
                if (press_n == 0) press_n = n;
            end
        end
        chk_range("reset_rise_latency", rise_n, 31, 35);
        chk("reset_rise_edge", rise_n, 32);
        chk("reset_press_count", cnt_a, 1);
        chk("reset_press_after_rise", press_n, rise_n + 1);

        buttons = '0;
        repeat (45) step();
        chk("all_released", results, 5'h00);

        bad = 0;
        for (int k = 0; k < 4; k++) begin
            buttons[0] = ~buttons[0];
            for (int n = 0; n < 10; n++) begin
                step();
                if (results[0]) bad++;
            end
        end
        buttons[0] = 1'b1;
        rise_n = 0; cnt_a = 0;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (results[0]) bad = (rise_n == 0) ? bad : bad;
            if (rise_n == 0 && results[0]) rise_n = n;
            if (press[0]) cnt_a++;
        end
        chk("bounce_stays_low", bad, 0);
        chk_range("bounce_rise_latency", rise_n, 31, 35);
        chk("bounce_press_count", cnt_a, 1);

        buttons[2] = 1'b1;
        repeat (45) step();
        chk("glitch_pre_high", results[2], 1'b1);
        buttons[2] = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int n = 0; n < 70; n++) begin
            if (n == 20) buttons[2] = 1'b1;
            step();
            if (!results[2]) cnt_a++;
            if (rel[2]) cnt_b++;
        end
        chk("glitch_level_kept", cnt_a, 0);
        chk("glitch_no_release", cnt_b, 0);

        buttons[1] = 1'b1;
        wait_bit("long_test_press", 1, 1, 50, w);
        wait_bit("long_test_long", 1, 3, 150, w);
        chk_range("long_press_latency", w, 77, 81);
        for (int k = 0; k < 3; k++) begin
            wait_bit("long_test_rpt", 1, 4, 40, w);
            chk("rpt_period", w, 20);
        end
        buttons[1] = 1'b0;
        wait_bit("long_test_release", 1, 2, 60, w);
        cnt_a = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (rpt[1] || long_press[1]) cnt_a++;
        end
        chk("no_rpt_after_release", cnt_a, 0);

        buttons[3] = 1'b1;
        buttons[4] = 1'b1;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int n = 0; n < 70; n++) begin
            if (n == 10) buttons[4] = 1'b0;
            step();
            if (press[3]) cnt_a++;
            if (press[4]) cnt_b++;
            if (results[4]) cnt_c++;
        end
        chk("parallel_press3", cnt_a, 1);
        chk("parallel_press4", cnt_b, 0);
        chk("parallel_results4", cnt_c, 0);

        buttons[1] = 1'b1;
        wait_bit("midrst_press", 1, 1, 50, w);
        wait_bit("midrst_rpt", 1, 4, 150, w);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_async_clear", {results, press, rel, long_press, rpt}, '0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        wait_bit("midrst_repress", 1, 1, 60, w);
        chk_range("midrst_redebounce", w, 32, 36);

        for (int it = 0; it < 60; it++) begin
            ch = $urandom_range(0, NC - 1);
            buttons[ch] = ~buttons[ch];
            dur = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : $urandom_range(30, 160);
            if ($urandom_range(0, 19) == 0) begin
                #2;
                rst_n = 1'b0;
                @(posedge clk);
                #3;
                rst_n = 1'b1;
                #1;
            end
            repeat (dur) step();
        end

        buttons = '0;
        repeat (60) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
